// File: rtl/paddle_input_arbiter.sv
// Per-player paddle position arbiter: picks analog stick or digital up/down
// (last active wins, digital beats analog on a tie), applies an accelerating
// saturating step for digital motion, and updates only on the vsync rising edge.
module paddle_input_arbiter #(
  parameter int DEADZONE = 8,
  parameter int STEP_MIN = 2,
  parameter int STEP_MAX = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vsync,
  input  logic [15:0] joy_analog_0,
  input  logic [15:0] joy_analog_1,
  input  logic        up_0,
  input  logic        down_0,
  input  logic        up_1,
  input  logic        down_1,
  output logic [7:0]  paddle1_vpos,
  output logic [7:0]  paddle2_vpos,
  output logic [1:0]  src_0,
  output logic [1:0]  src_1
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAnalog  = 2'd1,
    StDigital = 2'd2
  } state_e;

  localparam logic [6:0] StepMin = 7'(STEP_MIN);
  localparam logic [6:0] StepMax = 7'(STEP_MAX);

  logic       vsync_q;
  logic       tick;

  state_e     state_q   [2];
  state_e     state_d   [2];
  logic [7:0] vpos_q    [2];
  logic [7:0] vpos_d    [2];
  logic [6:0] step_q    [2];
  logic [6:0] step_d    [2];
  logic       dir_q     [2];  // 1 = down, 0 = up
  logic       dir_d     [2];
  logic       dir_vld_q [2];  // a direction was held on the previous tick
  logic       dir_vld_d [2];

  logic [7:0] joy_y   [2];
  logic       up      [2];
  logic       down    [2];
  logic       ana_act [2];
  logic       dig_act [2];
  logic [8:0] sum     [2];

  logic unused_joy_x;
  assign unused_joy_x = ^{joy_analog_0[7:0], joy_analog_1[7:0]};

  assign tick = vsync & ~vsync_q;

  // Gather per-player inputs into arrays so both channels share one datapath description.
  always_comb begin
    joy_y[0] = joy_analog_0[15:8];
    joy_y[1] = joy_analog_1[15:8];
    up[0]    = up_0;
    up[1]    = up_1;
    down[0]  = down_0;
    down[1]  = down_1;
  end

  // Per-channel source selection, step acceleration and position update on the frame tick.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch]   = state_q[ch];
      vpos_d[ch]    = vpos_q[ch];
      step_d[ch]    = step_q[ch];
      dir_d[ch]     = dir_q[ch];
      dir_vld_d[ch] = dir_vld_q[ch];
      sum[ch]       = 9'd0;
      ana_act[ch]   = (int'($signed(joy_y[ch])) > DEADZONE) ||
                      (int'($signed(joy_y[ch])) < -DEADZONE);
      dig_act[ch]   = up[ch] ^ down[ch];

      if (tick) begin
        if (dig_act[ch]) begin
          state_d[ch] = StDigital;
        end else if (ana_act[ch]) begin
          state_d[ch] = StAnalog;
        end

        if (dig_act[ch]) begin
          if (dir_vld_q[ch] && (dir_q[ch] == down[ch])) begin
            step_d[ch] = (step_q[ch] >= StepMax) ? StepMax : step_q[ch] + 7'd1;
          end else begin
            step_d[ch] = StepMin;
          end
          dir_d[ch]     = down[ch];
          dir_vld_d[ch] = 1'b1;
        end else begin
          step_d[ch]    = StepMin;
          dir_d[ch]     = 1'b0;
          dir_vld_d[ch] = 1'b0;
        end

        case (state_d[ch])
          StIdle:   vpos_d[ch] = 8'h80;
          // Offset-binary conversion: adding 0x80 mod 256 is an MSB flip.
          StAnalog: vpos_d[ch] = {~joy_y[ch][7], joy_y[ch][6:0]};
          StDigital: begin
            if (dig_act[ch]) begin
              if (down[ch]) begin
                sum[ch]    = {1'b0, vpos_q[ch]} + {2'b00, step_d[ch]};
                vpos_d[ch] = sum[ch][8] ? 8'hFF : sum[ch][7:0];
              end else begin
                sum[ch]    = {1'b0, vpos_q[ch]} - {2'b00, step_d[ch]};
                vpos_d[ch] = sum[ch][8] ? 8'h00 : sum[ch][7:0];
              end
            end
          end
          default:  vpos_d[ch] = 8'h80;
        endcase
      end
    end
  end

  // State registers; vsync_q resets high so an already-high vsync does not tick.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vsync_q <= 1'b1;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch]   <= StIdle;
        vpos_q[ch]    <= 8'h80;
        step_q[ch]    <= StepMin;
        dir_q[ch]     <= 1'b0;
        dir_vld_q[ch] <= 1'b0;
      end
    end else begin
      vsync_q <= vsync;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch]   <= state_d[ch];
        vpos_q[ch]    <= vpos_d[ch];
        step_q[ch]    <= step_d[ch];
        dir_q[ch]     <= dir_d[ch];
        dir_vld_q[ch] <= dir_vld_d[ch];
      end
    end
  end

  assign paddle1_vpos = vpos_q[0];
  assign paddle2_vpos = vpos_q[1];
  assign src_0        = state_q[0];
  assign src_1        = state_q[1];

endmodule

// File: tb/tb_paddle_input_arbiter.sv
// Scoreboard bench for paddle_input_arbiter: stimulus pushes the expected
// post-tick outputs from a behavioural model; a monitor pops them after each
// tick or reset and checks that outputs hold steady in between.
module tb_paddle_input_arbiter;

  localparam int DZ   = 8;
  localparam int SMIN = 2;
  localparam int SMAX = 8;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        vsync;
  logic [15:0] joy_analog_0;
  logic [15:0] joy_analog_1;
  logic        up_0, down_0, up_1, down_1;
  logic [7:0]  paddle1_vpos, paddle2_vpos;
  logic [1:0]  src_0, src_1;

  paddle_input_arbiter #(
    .DEADZONE(DZ),
    .STEP_MIN(SMIN),
    .STEP_MAX(SMAX)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .vsync        (vsync),
    .joy_analog_0 (joy_analog_0),
    .joy_analog_1 (joy_analog_1),
    .up_0         (up_0),
    .down_0       (down_0),
    .up_1         (up_1),
    .down_1       (down_1),
    .paddle1_vpos (paddle1_vpos),
    .paddle2_vpos (paddle2_vpos),
    .src_0        (src_0),
    .src_1        (src_1)
  );

  always #5 clk_sys = ~clk_sys;

  int          total = 0;
  int          bad   = 0;
  logic [19:0] exp_q[$];
  logic [19:0] cur   = {8'h80, 2'd0, 8'h80, 2'd0};

  // Model: src 0/1/2, position 0..255, step, last direction (-1 up, +1 down, 0 none).
  int m_src[2], m_vpos[2], m_step[2], m_dir[2];

  function automatic logic [19:0] pack_model();
    return {8'(m_vpos[0]), 2'(m_src[0]), 8'(m_vpos[1]), 2'(m_src[1])};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s @%0t: got p1=%02h s0=%0d p2=%02h s1=%0d, want p1=%02h s0=%0d p2=%02h s1=%0d",
               name, $time, act[19:12], act[11:10], act[9:2], act[1:0],
               want[19:12], want[11:10], want[9:2], want[1:0]);
    end
  endtask

  task automatic pop_check(input string name);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s @%0t: output event with empty scoreboard, got p1=%02h p2=%02h want none",
               name, $time, paddle1_vpos, paddle2_vpos);
    end else begin
      cur = exp_q.pop_front();
      check(name, {paddle1_vpos, src_0, paddle2_vpos, src_1}, cur);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_src[p]  = 0;
      m_vpos[p] = 128;
      m_step[p] = SMIN;
      m_dir[p]  = 0;
    end
  endtask

  task automatic model_tick(input int p, input logic [7:0] y, input logic u, input logic d);
    int a;
    int mv;
    int np;
    bit ana;
    bit dig;
    a   = int'($signed(y));
    ana = (a > DZ) || (a < -DZ);
    dig = u ^ d;
    mv  = 0;
    if (dig) m_src[p] = 2;
    else if (ana) m_src[p] = 1;
    if (dig) begin
      mv = u ? -1 : 1;
      if (m_dir[p] == mv) m_step[p] = (m_step[p] + 1 > SMAX) ? SMAX : m_step[p] + 1;
      else m_step[p] = SMIN;
      m_dir[p] = mv;
    end else begin
      m_step[p] = SMIN;
      m_dir[p]  = 0;
    end
    case (m_src[p])
      0: m_vpos[p] = 128;
      1: m_vpos[p] = a + 128;
      default: begin
        if (dig) begin
          np = m_vpos[p] + mv * m_step[p];
          m_vpos[p] = (np < 0) ? 0 : (np > 255) ? 255 : np;
        end
      end
    endcase
  endtask

  // Inputs outside the tick cycle must not matter.
  task automatic scramble();
    joy_analog_0 = 16'($urandom);
    joy_analog_1 = 16'($urandom);
    up_0   = 1'($urandom);
    down_0 = 1'($urandom);
    up_1   = 1'($urandom);
    down_1 = 1'($urandom);
  endtask

  task automatic do_tick(input logic [7:0] y0, input logic [7:0] y1, input logic u0,
                         input logic d0, input logic u1, input logic d1, input int hold);
    @(negedge clk_sys);
    joy_analog_0 = {y0, 8'($urandom)};
    joy_analog_1 = {y1, 8'($urandom)};
    up_0   = u0;
    down_0 = d0;
    up_1   = u1;
    down_1 = d1;
    vsync  = 1'b1;
    model_tick(0, y0, u0, d0);
    model_tick(1, y1, u1, d1);
    exp_q.push_back(pack_model());
    repeat (hold) begin
      @(negedge clk_sys);
      scramble();
    end
    @(negedge clk_sys);
    vsync = 1'b0;
    repeat ($urandom_range(2, 5)) begin
      @(negedge clk_sys);
      scramble();
    end
  endtask

  task automatic tk(input logic [7:0] y0, input logic [7:0] y1, input logic u0,
                    input logic d0, input logic u1, input logic d1);
    do_tick(y0, y1, u0, d0, u1, d1, $urandom_range(1, 4));
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    model_reset();
    exp_q.push_back(pack_model());
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  // Monitor: compare after every reset edge and one edge after each tick; hold-check otherwise.
  initial begin
    logic rs;
    logic vs;
    bit   vprev;
    bit   pend;
    vprev = 1'b1;
    pend  = 1'b0;
    forever begin
      @(posedge clk_sys);
      rs = reset;
      vs = vsync;
      #1;
      if (rs) begin
        pend  = 1'b0;
        vprev = 1'b1;
        pop_check("reset");
      end else begin
        if (pend) begin
          pend = 1'b0;
          pop_check("tick");
        end else if (!(vs && !vprev)) begin
          check("hold", {paddle1_vpos, src_0, paddle2_vpos, src_1}, cur);
        end
        if (vs && !vprev) pend = 1'b1;
        vprev = vs;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ry0, ry1;
    logic       ru0, rd0, ru1, rd1;
    reset        = 1'b1;
    vsync        = 1'b1;  // high across reset release: must not tick
    joy_analog_0 = '0;
    joy_analog_1 = '0;
    up_0 = 1'b0; down_0 = 1'b0; up_1 = 1'b0; down_1 = 1'b0;
    model_reset();
    exp_q.push_back(pack_model());
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (4) @(negedge clk_sys);
    vsync = 1'b0;
    repeat (3) @(negedge clk_sys);

    // Idle frames
    repeat (3) tk(8'h00, 8'h00, 0, 0, 0, 0);
    // Deadzone, then analog -64
    tk(8'h05, 8'h00, 0, 0, 0, 0);
    tk(8'hC0, 8'h00, 0, 0, 0, 0);
    // Digital takes over from analog, accelerating down
    repeat (5) tk(8'hC0, 8'h00, 0, 1, 0, 0);
    // Analog to 0x03, then up into the top rail, then reverse
    tk(8'h83, 8'h00, 0, 0, 0, 0);
    repeat (3) tk(8'h83, 8'h00, 1, 0, 0, 0);
    tk(8'h83, 8'h00, 0, 1, 0, 0);
    // Both buttons pressed on P2 is no activity; then analog +100
    repeat (2) tk(8'h00, 8'h00, 0, 0, 1, 1);
    tk(8'h00, 8'h64, 0, 0, 0, 0);
    // P2 to 0xFE, down into the bottom rail; long vsync high counts once
    tk(8'h00, 8'h7E, 0, 0, 0, 0);
    do_tick(8'h00, 8'h7E, 0, 0, 0, 1, 20);
    repeat (2) tk(8'h00, 8'h7E, 0, 0, 0, 1);
    // Step ceiling on P1
    tk(8'h90, 8'h00, 0, 0, 0, 0);
    repeat (12) tk(8'h00, 8'h00, 0, 1, 0, 0);
    // Reset mid-press loses step and direction
    tk(8'hA0, 8'h00, 0, 0, 0, 0);
    repeat (4) tk(8'h00, 8'h00, 0, 1, 0, 0);
    down_0 = 1'b1;
    do_reset();
    down_0 = 1'b1;
    tk(8'h00, 8'h00, 0, 1, 0, 0);

    // Randomized frames with sticky buttons so acceleration runs occur
    ry0 = 8'h00; ry1 = 8'h00;
    ru0 = 0; rd0 = 0; ru1 = 0; rd1 = 0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) ry0 = 8'($urandom_range(0, 2 * DZ) - DZ);
      else if ($urandom_range(0, 3) == 0) ry0 = 8'($urandom);
      if ($urandom_range(0, 2) == 0) ry1 = 8'($urandom_range(0, 2 * DZ) - DZ);
      else if ($urandom_range(0, 3) == 0) ry1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin ru0 = 1'($urandom); rd0 = 1'($urandom); end
      if ($urandom_range(0, 3) == 0) begin ru1 = 1'($urandom); rd1 = 1'($urandom); end
      tk(ry0, ry1, ru0, rd0, ru1, rd1);
      if (i == 75) do_reset();
    end

    repeat (5) @(negedge clk_sys);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: scoreboard entries left got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
